signal_analyzer: RTL

Measurement block at the receive end of the waveform path. It samples an 8-bit ADC stream of the signal the generator drives out on its DAC. Over a fixed gate window of sys_clk cycles it counts rising midline crossings (with hysteresis) and tracks minimum and maximum sample values. At the end of each window it latches frequency count, extremes, peak-to-peak and an adaptive midline for display and self-test logic.

---
 rtl/signal_analyzer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/signal_analyzer.sv
// Gated waveform measurement: rising midline crossings with hysteresis, min/max
// and peak-to-peak per gate window, with an adaptive midline updated at each close.
module signal_analyzer #(
    parameter int GATE_CYCLES = 1_000_000,
    parameter int HYST        = 8,
    parameter int CNT_W       = 20
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [7:0]       wave_in,
    output logic [CNT_W-1:0] freq_count,
    output logic [7:0]       wave_max,
    output logic [7:0]       wave_min,
    output logic [7:0]       wave_pp,
    output logic [7:0]       midline,
    output logic             overflow,
    output logic             result_valid,
    output logic             cross_high
);

    localparam int              GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [8:0]        HYST9     = 9'(HYST);

    typedef enum logic {
        CROSS_LOW  = 1'b0,
        CROSS_HIGH = 1'b1
    } cross_t;

    logic [GATE_W-1:0] gate_q, gate_d;
    cross_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              has_q, has_d;
    logic [7:0]        min_q, min_d, max_q, max_d;

    logic [CNT_W-1:0]  freq_q, freq_d;
    logic [7:0]        wmax_q, wmax_d, wmin_q, wmin_d, pp_q, pp_d, mid_q, mid_d;
    logic              ovf_q, ovf_d, rv_q, rv_d;

    logic              accept, rise;
    logic [8:0]        hi_sum, lo_dif, mid_sum;
    logic [7:0]        thr_hi, thr_lo;
    cross_t            state_upd;
    logic [CNT_W-1:0]  cnt_upd;
    logic              ovf_upd, has_upd;
    logic [7:0]        min_upd, max_upd;

    always_comb begin
        accept = enable & sample_valid;
        hi_sum = {1'b0, mid_q} + HYST9;
        lo_dif = {1'b0, mid_q} - HYST9;
        thr_hi = hi_sum[8] ? 8'hFF : hi_sum[7:0];
        thr_lo = lo_dif[8] ? 8'h00 : lo_dif[7:0];

        // Same-cycle view of the accumulators including the current sample.
        state_upd = state_q;
        rise      = 1'b0;
        if (accept) begin
            if (state_q == CROSS_LOW && wave_in >= thr_hi) begin
                state_upd = CROSS_HIGH;
                rise      = 1'b1;
            end else if (state_q == CROSS_HIGH && wave_in <= thr_lo) begin
                state_upd = CROSS_LOW;
            end
        end

        cnt_upd = cnt_q;
        ovf_upd = ovf_acc_q;
        if (rise) begin
            if (cnt_q == CNT_MAX) ovf_upd = 1'b1;
            else                  cnt_upd = cnt_q + CNT_W'(1);
        end

        has_upd = has_q;
        min_upd = min_q;
        max_upd = max_q;
        if (accept) begin
            has_upd = 1'b1;
            if (!has_q) begin
                min_upd = wave_in;
                max_upd = wave_in;
            end else begin
                if (wave_in < min_q) min_upd = wave_in;
                if (wave_in > max_q) max_upd = wave_in;
            end
        end
        mid_sum = {1'b0, max_upd} + {1'b0, min_upd};

        gate_d    = gate_q;
        state_d   = state_upd;
        cnt_d     = cnt_upd;
        ovf_acc_d = ovf_upd;
        has_d     = has_upd;
        min_d     = min_upd;
        max_d     = max_upd;
        freq_d    = freq_q;
        wmax_d    = wmax_q;
        wmin_d    = wmin_q;
        pp_d      = pp_q;
        mid_d     = mid_q;
        ovf_d     = ovf_q;
        rv_d      = 1'b0;

        if (!enable) begin
            gate_d    = '0;
            state_d   = CROSS_LOW;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
            has_d     = 1'b0;
            min_d     = 8'd0;
            max_d     = 8'd0;
        end else if (gate_q == GATE_LAST) begin
            gate_d    = '0;
            rv_d      = 1'b1;
            freq_d    = cnt_upd;
            ovf_d     = ovf_upd;
            if (has_upd) begin
                wmax_d = max_upd;
                wmin_d = min_upd;
                pp_d   = max_upd - min_upd;
                mid_d  = mid_sum[8:1];
            end else begin
                wmax_d = 8'd0;
                wmin_d = 8'd0;
                pp_d   = 8'd0;
            end
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
            has_d     = 1'b0;
            min_d     = 8'd0;
            max_d     = 8'd0;
        end else begin
            gate_d = gate_q + GATE_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            gate_q    <= '0;
            state_q   <= CROSS_LOW;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            has_q     <= 1'b0;
            min_q     <= 8'd0;
            max_q     <= 8'd0;
            freq_q    <= '0;
            wmax_q    <= 8'd0;
            wmin_q    <= 8'd0;
            pp_q      <= 8'd0;
            mid_q     <= 8'd128;
            ovf_q     <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            gate_q    <= gate_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            has_q     <= has_d;
            min_q     <= min_d;
            max_q     <= max_d;
            freq_q    <= freq_d;
            wmax_q    <= wmax_d;
            wmin_q    <= wmin_d;
            pp_q      <= pp_d;
            mid_q     <= mid_d;
            ovf_q     <= ovf_d;
            rv_q      <= rv_d;
        end
    end

    assign freq_count   = freq_q;
    assign wave_max     = wmax_q;
    assign wave_min     = wmin_q;
    assign wave_pp      = pp_q;
    assign midline      = mid_q;
    assign overflow     = ovf_q;
    assign result_valid = rv_q;
    assign cross_high   = (state_q == CROSS_HIGH);

endmodule
